// File: rtl/dram_sched.sv
// DRAM sequencer: arbitrates 6502 register accesses, the aux copy/fill engine and CBR refresh,
// and owns all RAS/CAS/ASel timing so requesters only see a req/ack handshake.
module dram_sched #(
  parameter int REF_PERIOD  = 108,
  parameter int CAS_CYC     = 2,
  parameter int PRE_CYC     = 1,
  parameter int REF_RAS_CYC = 2
) (
  input  logic       C7M,
  input  logic       RES,
  input  logic       bus_req,
  input  logic       bus_we,
  input  logic       bus_bank,
  output logic       bus_ack,
  input  logic       aux_req,
  input  logic       aux_we,
  input  logic       aux_bank,
  output logic       aux_ack,
  output logic       nRAS,
  output logic       nCAS0,
  output logic       nCAS1,
  output logic       ASel,
  output logic       grant_aux,
  output logic [1:0] ref_pend,
  output logic       busy,
  output logic       we
);

  localparam int TW = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;

  typedef enum logic [2:0] {
    IDLE, ROW, COL, CAS, PRE, RCAS, RRAS
  } state_t;

  state_t        state;
  logic [7:0]    cnt;
  logic [TW-1:0] timer;
  logic          bank;
  logic          tmr_wrap;
  logic          ref_start;

  // Overdue refresh beats the bus; any owed refresh beats aux.
  always_comb begin
    tmr_wrap  = (timer == TW'(REF_PERIOD - 1));
    ref_start = (state == IDLE) &&
                ((ref_pend == 2'd3) || (!bus_req && (ref_pend != 2'd0)));
  end

  always_ff @(posedge C7M or posedge RES) begin
    if (RES) begin
      state     <= IDLE;
      cnt       <= '0;
      timer     <= '0;
      bank      <= 1'b0;
      we        <= 1'b0;
      ref_pend  <= 2'd0;
      bus_ack   <= 1'b0;
      aux_ack   <= 1'b0;
      nRAS      <= 1'b1;
      nCAS0     <= 1'b1;
      nCAS1     <= 1'b1;
      ASel      <= 1'b0;
      grant_aux <= 1'b0;
      busy      <= 1'b0;
    end else begin
      timer <= tmr_wrap ? '0 : timer + 1'b1;
      if (tmr_wrap && !ref_start && (ref_pend != 2'd3))
        ref_pend <= ref_pend + 2'd1;
      else if (ref_start && !tmr_wrap)
        ref_pend <= ref_pend - 2'd1;

      bus_ack <= 1'b0;
      aux_ack <= 1'b0;

      case (state)
        IDLE: begin
          if (ref_start) begin
            // CBR: CAS falls first with RAS still high
            state <= RCAS;
            nCAS0 <= 1'b0;
            nCAS1 <= 1'b0;
            busy  <= 1'b1;
          end else if (bus_req || aux_req) begin
            state     <= ROW;
            nRAS      <= 1'b0;
            busy      <= 1'b1;
            grant_aux <= !bus_req;
            bank      <= bus_req ? bus_bank : aux_bank;
            we        <= bus_req ? bus_we   : aux_we;
          end
        end
        ROW: begin
          state <= COL;
          ASel  <= 1'b1;
        end
        COL: begin
          state   <= CAS;
          cnt     <= 8'(CAS_CYC - 1);
          nCAS0   <= bank;
          nCAS1   <= !bank;
          bus_ack <= !grant_aux;
          aux_ack <= grant_aux;
        end
        CAS: begin
          if (cnt == 8'd0) begin
            state     <= PRE;
            cnt       <= 8'(PRE_CYC - 1);
            nRAS      <= 1'b1;
            nCAS0     <= 1'b1;
            nCAS1     <= 1'b1;
            ASel      <= 1'b0;
            grant_aux <= 1'b0;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        PRE: begin
          if (cnt == 8'd0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        RCAS: begin
          state <= RRAS;
          cnt   <= 8'(REF_RAS_CYC - 1);
          nRAS  <= 1'b0;
        end
        RRAS: begin
          if (cnt == 8'd0) begin
            state <= PRE;
            cnt   <= 8'(PRE_CYC - 1);
            nRAS  <= 1'b1;
            nCAS0 <= 1'b1;
            nCAS1 <= 1'b1;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: begin
          state <= IDLE;
          nRAS  <= 1'b1;
          nCAS0 <= 1'b1;
          nCAS1 <= 1'b1;
          ASel  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
